// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// The state encoding matches the values used by debug tooling on dbg_state.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    // Elaboration-time ceil(log2(value)), with a minimum result of 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit strictly after
// last_winner, wrapping around, so last_winner itself has lowest priority.
module rr_priority_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        winner_onehot = '0;
        winner_idx    = '0;
        found         = 1'b0;
        cand          = 0;
        cand_idx      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = int'(last_winner) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                winner_idx    = cand_idx;
                winner_onehot = NUM_REQ'(1) << cand_idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin
// arbitration; one DATA_VALID strobe per granted byte, then waits out the frame.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [DATA_WIDTH-1:0]         TX_P_DATA,
    output logic                          TX_DATA_VALID,
    input  logic                          TX_BUSY,
    input  logic                          TX_DATA_LOST,
    output logic                          ARB_BUSY,
    output logic [clog2(NUM_REQ)-1:0]     GNT_ID,
    output logic                          ERR_TIMEOUT,
    output logic                          ERR_LOST,
    output arb_state_t                    dbg_state
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    // Handshake: requester i raises REQ[i] with its byte on slice i and holds
    // both until GNT[i] pulses; the byte is consumed on that pulse. REQ is only
    // sampled in IDLE, so a request left high during a frame is not re-granted.

    arb_state_t              state;
    arb_state_t              state_n;
    logic [IDX_W-1:0]        last_winner;
    logic [NUM_REQ-1:0]      gnt_pending;
    logic [CNT_W-1:0]        busy_cnt;
    logic                    lost_seen;
    logic                    timeout_hit;
    logic [NUM_REQ-1:0]      pick_onehot;
    logic [IDX_W-1:0]        pick_idx;
    logic                    any_req;
    logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign req_bytes[g] = REQ_DATA[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req           (REQ),
        .last_winner   (last_winner),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx),
        .any_req       (any_req)
    );

    always_comb begin
        state_n     = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_n = LOAD;
                end
            end
            LOAD: state_n = WAIT_BUSY;
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_n = WAIT_DONE;
                end else if (busy_cnt == CNT_LAST) begin
                    state_n     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_winner   <= IDX_W'(NUM_REQ - 1);
            gnt_pending   <= '0;
            busy_cnt      <= '0;
            lost_seen     <= 1'b0;
            GNT           <= '0;
            TX_P_DATA     <= '0;
            TX_DATA_VALID <= 1'b0;
            ARB_BUSY      <= 1'b0;
            GNT_ID        <= '0;
            ERR_TIMEOUT   <= 1'b0;
            ERR_LOST      <= 1'b0;
        end else begin
            state         <= state_n;
            ARB_BUSY      <= (state_n != IDLE);
            GNT           <= '0;
            TX_DATA_VALID <= 1'b0;
            ERR_TIMEOUT   <= timeout_hit;
            ERR_LOST      <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        TX_P_DATA   <= req_bytes[pick_idx];
                        last_winner <= pick_idx;
                        GNT_ID      <= pick_idx;
                        gnt_pending <= pick_onehot;
                        lost_seen   <= 1'b0;
                        busy_cnt    <= '0;
                    end
                end
                LOAD: begin
                    GNT           <= gnt_pending;
                    TX_DATA_VALID <= 1'b1;
                end
                WAIT_BUSY: begin
                    if (TX_BUSY || timeout_hit) begin
                        busy_cnt <= '0;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
            // One loss report per frame, whichever owned state it lands in.
            if ((state != IDLE) && TX_DATA_LOST && !lost_seen) begin
                ERR_LOST  <= 1'b1;
                lost_seen <= 1'b1;
            end
        end
    end

    assign dbg_state = state;

endmodule
